// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    localparam logic [CW-1:0] START_END = CW'(HALF - 1 + LAG);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic          rx_s1, rxs, bit_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rxs   <= rx_s1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rxs one cycle back (mid), hist[1] two back (mid-1); rxs itself is mid+1
    logic [1:0] hist;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hist <= 2'b11;
        else         hist <= {hist[0], rxs};
    end
    assign bit_s = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
    assign bit_s = rxs;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (cnt == START_END) begin
                        cnt   <= '0;
                        state <= bit_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {bit_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (bit_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Byte is written on the stop-sample edge itself, so it shows on the next cycle.
    logic          push_req, push, pop;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    assign push_req = (state == STOP) && (cnt == BIT_END) && bit_s;
    assign pop      = rd_valid && rd_ready;
    assign push     = push_req && ((count != FULL) || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push) overrun <= 1'b1;
            else if (clr_err)      overrun <= 1'b0;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rptr] : 8'h00;
    assign fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default 104 clocks per bit.
module tb_uart_rx_fifo;
    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       resetn, uart_rx, rd_ready, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, busy, frame_err, overrun;
    logic [4:0] fifo_count;

    int ncmp = 0;
    int nerr = 0;
    int ferr_cnt = 0;

    uart_rx_fifo dut (
        .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(BIT);
        end
        uart_rx = stop;
        idle(BIT);
    endtask

    task automatic pop1();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic       exp_push;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int f0;
        logic [7:0] exp_b;

        tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        tbl[3] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        tbl[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};

        resetn = 1'b0; uart_rx = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
        idle(3);
        chk("reset rd_data", rd_data, 8'h00);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset count", fifo_count, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        resetn = 1'b1;
        idle(5);

        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].tx, tbl[i].stop);
            uart_rx = 1'b1;
            idle(20);
            chk($sformatf("vec%0d rd_valid", i), rd_valid, tbl[i].exp_push);
            if (tbl[i].exp_push) chk($sformatf("vec%0d rd_data", i), rd_data, tbl[i].exp_data);
            chk($sformatf("vec%0d frame_err", i), ferr_cnt - f0, tbl[i].exp_ferr);
            chk($sformatf("vec%0d busy", i), busy, 0);
            if (rd_valid) pop1();
        end

        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        idle(20);
        chk("two count", fifo_count, 2);
        chk("two head0", rd_data, 8'h55);
        pop1();
        chk("two head1", rd_data, 8'hA3);
        chk("two count1", fifo_count, 1);
        pop1();
        chk("two count0", fifo_count, 0);
        pop1();
        chk("empty pop count", fifo_count, 0);
        chk("empty pop valid", rd_valid, 0);

        f0 = ferr_cnt;
        uart_rx = 1'b0;
        idle(10);
        chk("glitch busy", busy, 1);
        idle(20);
        uart_rx = 1'b1;
        idle(150);
        chk("glitch idle", busy, 0);
        chk("glitch no push", fifo_count, 0);
        chk("glitch no ferr", ferr_cnt - f0, 0);

        f0 = ferr_cnt;
        send_frame(8'h41, 1'b0);
        idle(2000);
        uart_rx = 1'b1;
        idle(20);
        chk("break ferr once", ferr_cnt - f0, 1);
        chk("break no push", fifo_count, 0);
        chk("break idle", busy, 0);
        send_frame(8'h42, 1'b1);
        idle(20);
        chk("after break data", rd_data, 8'h42);
        chk("after break count", fifo_count, 1);
        pop1();

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        idle(20);
        chk("full count", fifo_count, 16);
        chk("full overrun", overrun, 1);
        chk("full head", rd_data, 8'h00);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr overrun", overrun, 0);
        // Start bit lands on this negedge; stop sample is the 991st posedge after it.
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (990) @(posedge clk);
                @(negedge clk);
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        idle(20);
        chk("push+pop full count", fifo_count, 16);
        chk("push+pop full overrun", overrun, 0);
        for (int i = 1; i <= 16; i++) begin
            exp_b = (i == 16) ? 8'h11 : 8'(i);
            chk($sformatf("drain %0d", i), rd_data, exp_b);
            pop1();
        end
        chk("drain empty", fifo_count, 0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        idle(20);
        chk("pre-reset count", fifo_count, 3);
        uart_rx = 1'b0;
        idle(BIT);
        uart_rx = 1'b1;
        idle(200);
        chk("mid-frame busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("async rst count", fifo_count, 0);
        chk("async rst busy", busy, 0);
        chk("async rst valid", rd_valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle(20);
        send_frame(8'h7E, 1'b1);
        idle(20);
        chk("post-reset data", rd_data, 8'h7E);
        chk("post-reset count", fifo_count, 1);
        pop1();

`ifdef UART_RX_MAJORITY_EN
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h0F, 1'b0};
            for (int k = 0; k < 10; k++) begin
                uart_rx = bits[k];
                idle(52);
                uart_rx = ~bits[k];
                @(negedge clk);
                uart_rx = bits[k];
                idle(51);
            end
            idle(20);
            chk("spike data", rd_data, 8'h0F);
            chk("spike count", fifo_count, 1);
            pop1();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
